// File: rtl/reg_value_bcd_encoder_pkg.sv
// Shared constants, state encoding and helpers for the sequential binary-to-BCD encoder.
package reg_value_bcd_encoder_pkg;

   localparam int unsigned DIGIT_W    = 4;
   localparam int unsigned NUM_DIGITS = 3;
   localparam int unsigned VALUE_W    = 8;
   localparam int unsigned SCRATCH_W  = DIGIT_W * NUM_DIGITS;

   // Active-low abcdefg patterns
   localparam logic [1:7] SEG_0     = 7'b0000001;
   localparam logic [1:7] SEG_1     = 7'b1001111;
   localparam logic [1:7] SEG_2     = 7'b0010010;
   localparam logic [1:7] SEG_3     = 7'b0000110;
   localparam logic [1:7] SEG_4     = 7'b1001100;
   localparam logic [1:7] SEG_5     = 7'b0100100;
   localparam logic [1:7] SEG_6     = 7'b0100000;
   localparam logic [1:7] SEG_7     = 7'b0001111;
   localparam logic [1:7] SEG_8     = 7'b0000000;
   localparam logic [1:7] SEG_9     = 7'b0000100;
   localparam logic [1:7] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FINISH = 2'd2
   } state_t;

   // Double-dabble correction: digits of 5 or more get +3 before the shift.
   function automatic logic [DIGIT_W-1:0] dabble_adjust(input logic [DIGIT_W-1:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

endpackage

// File: rtl/reg_value_bcd_encoder_seg7_digit_decode.sv
// Combinational BCD digit to active-low seven-segment pattern with a blank override.
module seg7_digit_decode
   import reg_value_bcd_encoder_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit,
   input  logic               blank,
   output logic [1:7]         seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank) begin
         case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/reg_value_bcd_encoder.sv
// Handshaked 8-bit to 3-digit BCD converter (shift-and-add-3) with registered
// seven-segment outputs for a four-digit display.
module reg_value_bcd_encoder
   import reg_value_bcd_encoder_pkg::*;
#(
   parameter int unsigned BLANK_LZ = 0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 start,
   input  logic [VALUE_W-1:0]   value,
   output logic                 busy,
   output logic                 done,
   output logic [SCRATCH_W-1:0] bcd,
   output logic [1:7]           display3,
   output logic [1:7]           display2,
   output logic [1:7]           display1,
   output logic [1:7]           display0
);

   localparam int unsigned SR_W = SCRATCH_W + VALUE_W;
   localparam bit BlankLz = (BLANK_LZ != 0);
   localparam logic [1:7] LeadSeg = BlankLz ? SEG_BLANK : SEG_0;

   state_t                 state_q, state_d;
   logic [SR_W-1:0]        shift_q, shift_d, shift_adj;
   logic [2:0]             cnt_q, cnt_d;
   logic [SCRATCH_W-1:0]   bcd_q, bcd_d;
   logic                   done_q, done_d;
   logic [1:7]             disp3_q, disp3_d, disp2_q, disp2_d;
   logic [1:7]             disp1_q, disp1_d, disp0_q, disp0_d;

   logic [DIGIT_W-1:0]     hund, tens, ones;
   logic                   blank_hund, blank_tens;
   logic [1:7]             seg_hund, seg_tens, seg_ones;

   assign hund = shift_q[VALUE_W + 2*DIGIT_W +: DIGIT_W];
   assign tens = shift_q[VALUE_W + DIGIT_W   +: DIGIT_W];
   assign ones = shift_q[VALUE_W             +: DIGIT_W];

   assign blank_hund = BlankLz && (hund == '0);
   assign blank_tens = blank_hund && (tens == '0);

   seg7_digit_decode u_dec_hund (
      .digit (hund),
      .blank (blank_hund),
      .seg   (seg_hund)
   );

   seg7_digit_decode u_dec_tens (
      .digit (tens),
      .blank (blank_tens),
      .seg   (seg_tens)
   );

   seg7_digit_decode u_dec_ones (
      .digit (ones),
      .blank (1'b0),
      .seg   (seg_ones)
   );

   always_comb begin
      shift_adj = shift_q;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         shift_adj[VALUE_W + DIGIT_W*i +: DIGIT_W] =
            dabble_adjust(shift_q[VALUE_W + DIGIT_W*i +: DIGIT_W]);
      end

      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      bcd_d   = bcd_q;
      done_d  = 1'b0;
      disp3_d = disp3_q;
      disp2_d = disp2_q;
      disp1_d = disp1_q;
      disp0_d = disp0_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               shift_d = {{SCRATCH_W{1'b0}}, value};
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            shift_d = shift_adj << 1;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) state_d = FINISH;
         end
         FINISH: begin
            bcd_d   = shift_q[SR_W-1 -: SCRATCH_W];
            disp3_d = LeadSeg;
            disp2_d = seg_hund;
            disp1_d = seg_tens;
            disp0_d = seg_ones;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         bcd_q   <= '0;
         done_q  <= 1'b0;
         disp3_q <= LeadSeg;
         disp2_q <= LeadSeg;
         disp1_q <= LeadSeg;
         disp0_q <= SEG_0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
         done_q  <= done_d;
         disp3_q <= disp3_d;
         disp2_q <= disp2_d;
         disp1_q <= disp1_d;
         disp0_q <= disp0_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign bcd      = bcd_q;
   assign display3 = disp3_q;
   assign display2 = disp2_q;
   assign display1 = disp1_q;
   assign display0 = disp0_q;

endmodule

// File: tb/tb_reg_value_bcd_encoder.sv
// Scoreboard bench: one DUT per BLANK_LZ mode sharing stimulus; a negedge monitor
// pops expected results on every done pulse.
module tb_reg_value_bcd_encoder;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [7:0] value = 8'd0;

   logic        busy0, done0, busy1, done1;
   logic [11:0] bcd0, bcd1;
   logic [1:7]  d30, d20, d10, d00, d31, d21, d11, d01;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [11:0] bcd;
      logic [6:0]  d3, d2, d1, d0;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t e0, e1;

   localparam logic [6:0] BL = 7'b1111111;

   reg_value_bcd_encoder #(.BLANK_LZ(0)) dut0 (
      .clock(clock), .reset(reset), .start(start), .value(value),
      .busy(busy0), .done(done0), .bcd(bcd0),
      .display3(d30), .display2(d20), .display1(d10), .display0(d00)
   );

   reg_value_bcd_encoder #(.BLANK_LZ(1)) dut1 (
      .clock(clock), .reset(reset), .start(start), .value(value),
      .busy(busy1), .done(done1), .bcd(bcd1),
      .display3(d31), .display2(d21), .display1(d11), .display0(d01)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [6:0] seg(input int d);
      case (d)
         0: return 7'b0000001;
         1: return 7'b1001111;
         2: return 7'b0010010;
         3: return 7'b0000110;
         4: return 7'b1001100;
         5: return 7'b0100100;
         6: return 7'b0100000;
         7: return 7'b0001111;
         8: return 7'b0000000;
         9: return 7'b0000100;
         default: return BL;
      endcase
   endfunction

   function automatic exp_t model(input int v, input bit blz);
      exp_t r;
      int h, t, o;
      h = v / 100;
      t = (v / 10) % 10;
      o = v % 10;
      r.bcd = {4'(h), 4'(t), 4'(o)};
      r.d3  = blz ? BL : seg(0);
      r.d2  = (blz && h == 0) ? BL : seg(h);
      r.d1  = (blz && h == 0 && t == 0) ? BL : seg(t);
      r.d0  = seg(o);
      return r;
   endfunction

   always @(negedge clock) begin
      if (!reset) begin
         check("done_busy_overlap0", 32'(done0 & busy0), 0);
         check("done_busy_overlap1", 32'(done1 & busy1), 0);
         if (done0) begin
            if (q0.size() == 0) check("unexpected_done0", 32'(done0), 0);
            else begin
               e0 = q0.pop_front();
               check("sb0_bcd", 32'(bcd0), 32'(e0.bcd));
               check("sb0_disp", {4'h0, d30, d20, d10, d00}, {4'h0, e0.d3, e0.d2, e0.d1, e0.d0});
            end
         end
         if (done1) begin
            if (q1.size() == 0) check("unexpected_done1", 32'(done1), 0);
            else begin
               e1 = q1.pop_front();
               check("sb1_bcd", 32'(bcd1), 32'(e1.bcd));
               check("sb1_disp", {4'h0, d31, d21, d11, d01}, {4'h0, e1.d3, e1.d2, e1.d1, e1.d0});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic issue(input logic [7:0] v);
      start = 1'b1;
      value = v;
      q0.push_back(model(int'(v), 1'b0));
      q1.push_back(model(int'(v), 1'b1));
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int lat;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (done0) begin
            lat = i;
            check({tag, "_busy_at_done"}, 32'(busy0), 0);
            break;
         end
         check({tag, "_busy"}, 32'(busy0), 1);
      end
      check({tag, "_latency"}, lat, 9);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, 32'(busy0), 0);
      check({tag, "_done"}, 32'(done0), 0);
      check({tag, "_bcd"}, 32'(bcd0), 0);
      check({tag, "_disp0"}, {4'h0, d30, d20, d10, d00},
            {4'h0, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001});
      check({tag, "_disp1"}, {4'h0, d31, d21, d11, d01}, {4'h0, BL, BL, BL, 7'b0000001});
   endtask

   logic [7:0] bl_val [4] = '{8'd7, 8'd70, 8'd100, 8'd0};
   logic [6:0] bl_d2  [4] = '{BL, BL, 7'b1001111, BL};
   logic [6:0] bl_d1  [4] = '{BL, 7'b0001111, 7'b0000001, BL};
   logic [6:0] bl_d0  [4] = '{7'b0001111, 7'b0000001, 7'b0000001, 7'b0000001};

   initial begin
      int ndone, lat;

      repeat (2) tick();
      reset = 1'b0;
      repeat (5) tick();
      check_reset_outputs("reset");

      // 255 with hand-coded patterns
      issue(8'd255);
      wait_done("v255");
      check("v255_bcd", 32'(bcd0), 32'h255);
      check("v255_disp0", {4'h0, d30, d20, d10, d00},
            {4'h0, 7'b0000001, 7'b0010010, 7'b0100100, 7'b0100100});
      check("v255_disp1", {4'h0, d31, d21, d11, d01},
            {4'h0, BL, 7'b0010010, 7'b0100100, 7'b0100100});

      // back-to-back: second start issued in the done cycle
      issue(8'd137);
      wait_done("v137");
      check("v137_bcd", 32'(bcd0), 32'h137);
      issue(8'd0);
      check("b2b_busy", 32'(busy0), 1);
      wait_done("v0");
      check("v0_bcd", 32'(bcd0), 32'h000);

      // start pulses and value changes while busy are ignored
      issue(8'd42);
      ndone = 0;
      lat = -1;
      for (int c = 1; c <= 12; c++) begin
         start = (c == 3 || c == 5);
         value = (c == 3) ? 8'd99 : (c == 5) ? 8'd201 : 8'd42;
         tick();
         if (done0) begin
            ndone++;
            lat = c;
         end
      end
      start = 1'b0;
      check("interf_done_count", ndone, 1);
      check("interf_latency", lat, 9);
      check("interf_bcd", 32'(bcd0), 32'h042);

      // reset during the fourth shift aborts the conversion
      issue(8'd200);
      repeat (3) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      q0.delete();
      q1.delete();
      check_reset_outputs("abort");
      for (int c = 0; c < 12; c++) begin
         tick();
         check("abort_no_done", 32'(done0 | done1), 0);
      end
      issue(8'd9);
      wait_done("v9");
      check("v9_bcd", 32'(bcd0), 32'h009);

      // leading-zero blanking, hand-coded patterns
      for (int k = 0; k < 4; k++) begin
         issue(bl_val[k]);
         wait_done("blank");
         check("blank_disp", {4'h0, d31, d21, d11, d01},
               {4'h0, BL, bl_d2[k], bl_d1[k], bl_d0[k]});
         check("blank_bcd_true", 32'(bcd1), 32'(bcd0));
      end

      repeat (3) tick();
      check("sb_drain0", q0.size(), 0);
      check("sb_drain1", q1.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
